// File: rtl/vedic_mul_pipe.sv
// Three-stage pipelined WIDTHxWIDTH Vedic multiplier with per-operation
// signed/unsigned mode, valid/ready backpressure and a sideband tag.

module vedic_mul #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    generate
        if (N == 2) begin : g_base
            logic c1, c2, c3, k1, s1, s2, k2;

            assign c1 = a[1] & b[0];
            assign c2 = a[0] & b[1];
            assign c3 = a[1] & b[1];
            assign s1 = c1 ^ c2;
            assign k1 = c1 & c2;
            assign s2 = c3 ^ k1;
            assign k2 = c3 & k1;
            assign p  = {k2, s2, s1, a[0] & b[0]};
        end else begin : g_split
            localparam int unsigned H = N / 2;

            logic [N-1:0] q0, q1, q2, q3;
            logic [N:0]   mid;

            vedic_mul #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(q0));
            vedic_mul #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(q1));
            vedic_mul #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(q2));
            vedic_mul #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(q3));

            // Cross terms keep their carry (bit N) before the H-bit shift.
            assign mid = {1'b0, q1} + {1'b0, q2};
            assign p   = {q3, q0} + {{(H-1){1'b0}}, mid, {H{1'b0}}};
        end
    endgenerate
endmodule

module vedic_mul_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int unsigned H = WIDTH / 2;

    logic en;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic             in_neg;

    logic             s1_valid, s1_neg;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic [TAG_W-1:0] s1_tag;

    logic [WIDTH-1:0] pp_q0, pp_q1, pp_q2, pp_q3;

    logic             s2_valid, s2_neg;
    logic [WIDTH-1:0] s2_q0, s2_q1, s2_q2, s2_q3;
    logic [TAG_W-1:0] s2_tag;

    logic [WIDTH:0]     mid;
    logic [2*WIDTH-1:0] mag, res;

    // Single global stall: the whole pipe moves when the output slot frees.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        a_mag  = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
        b_mag  = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
        in_neg = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_neg   <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_neg   <= in_neg;
            s1_a     <= a_mag;
            s1_b     <= b_mag;
            s1_tag   <= in_tag;
        end
    end

    vedic_mul #(.N(H)) u_q0 (.a(s1_a[H-1:0]),     .b(s1_b[H-1:0]),     .p(pp_q0));
    vedic_mul #(.N(H)) u_q1 (.a(s1_a[WIDTH-1:H]), .b(s1_b[H-1:0]),     .p(pp_q1));
    vedic_mul #(.N(H)) u_q2 (.a(s1_a[H-1:0]),     .b(s1_b[WIDTH-1:H]), .p(pp_q2));
    vedic_mul #(.N(H)) u_q3 (.a(s1_a[WIDTH-1:H]), .b(s1_b[WIDTH-1:H]), .p(pp_q3));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_neg   <= 1'b0;
            s2_tag   <= '0;
            s2_q0    <= '0;
            s2_q1    <= '0;
            s2_q2    <= '0;
            s2_q3    <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_neg   <= s1_neg;
            s2_tag   <= s1_tag;
            s2_q0    <= pp_q0;
            s2_q1    <= pp_q1;
            s2_q2    <= pp_q2;
            s2_q3    <= pp_q3;
        end
    end

    always_comb begin
        mid = {1'b0, s2_q1} + {1'b0, s2_q2};
        mag = {s2_q3, s2_q0} + {{(H-1){1'b0}}, mid, {H{1'b0}}};
        res = s2_neg ? -mag : mag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_p     <= '0;
            out_tag   <= '0;
        end else if (en) begin
            out_valid <= s2_valid;
            out_p     <= res;
            out_tag   <= s2_tag;
        end
    end
endmodule
